mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/scan_prescaler.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared state encodings and constants for the two-digit mux scan controller.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_DIG0   = 2'd0,
        ST_BLANK0 = 2'd1,
        ST_DIG1   = 2'd2,
        ST_BLANK1 = 2'd3
    } scan_state_e;

    localparam logic [1:0] DIG_EN_0   = 2'b01;
    localparam logic [1:0] DIG_EN_1   = 2'b10;
    localparam logic [1:0] DIG_EN_OFF = 2'b00;

    localparam int PRESCALE_DEF  = 50000;
    localparam int BLANK_CYC_DEF = 4;

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 while enabled, pulses o_tick at terminal count.
module scan_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;

    assign o_tick = i_en & ~i_clr & (cnt_r == TC);

    // Slot counter; clear holds it at zero so a slot restarts cleanly after blanking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_en) begin
            if (cnt_r == TC) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Two-digit scan controller: prescaled digit select plus frame-aligned nibble commit.
// Optional blanking slots between digits are enabled with MUX_SCAN_BLANK_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int PRESCALE  = PRESCALE_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_s,
    output logic [3:0] o_w0,
    output logic [3:0] o_w1,
    output logic [1:0] o_dig_en,
    output logic       o_frame
);

    scan_state_e state_r, state_nxt_s;
    logic        tick_s, clr_s, frame_s, accept_s, commit_s, s_nxt_s;
    logic [1:0]  dig_en_nxt_s;
    logic        s_r, frame_r, ready_r, pending_r;
    logic [1:0]  dig_en_r;
    logic [3:0]  w0_r, w1_r;
    logic [7:0]  pend_data_r;

    scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_clr  (clr_s),
        .o_tick (tick_s)
    );

`ifdef MUX_SCAN_BLANK_EN
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BTC = BW'(BLANK_CYC - 1);

    logic [BW-1:0] blank_cnt_r, blank_cnt_nxt_s;
    logic          blank_done_s;

    assign clr_s        = (state_r == ST_BLANK0) || (state_r == ST_BLANK1);
    assign blank_done_s = i_en & clr_s & (blank_cnt_r == BTC);

    // Scan sequencing with blank slots; the frame boundary is BLANK1 -> DIG0
    always_comb begin
        state_nxt_s     = state_r;
        frame_s         = 1'b0;
        blank_cnt_nxt_s = blank_cnt_r;
        case (state_r)
            ST_DIG0: begin
                blank_cnt_nxt_s = {BW{1'b0}};
                if (tick_s) state_nxt_s = ST_BLANK0;
                else        state_nxt_s = ST_DIG0;
            end
            ST_BLANK0: begin
                if (blank_done_s) begin
                    state_nxt_s     = ST_DIG1;
                    blank_cnt_nxt_s = {BW{1'b0}};
                end else if (i_en) begin
                    blank_cnt_nxt_s = blank_cnt_r + BW'(1'b1);
                end else begin
                    blank_cnt_nxt_s = blank_cnt_r;
                end
            end
            ST_DIG1: begin
                blank_cnt_nxt_s = {BW{1'b0}};
                if (tick_s) state_nxt_s = ST_BLANK1;
                else        state_nxt_s = ST_DIG1;
            end
            ST_BLANK1: begin
                if (blank_done_s) begin
                    state_nxt_s     = ST_DIG0;
                    frame_s         = 1'b1;
                    blank_cnt_nxt_s = {BW{1'b0}};
                end else if (i_en) begin
                    blank_cnt_nxt_s = blank_cnt_r + BW'(1'b1);
                end else begin
                    blank_cnt_nxt_s = blank_cnt_r;
                end
            end
            default: begin
                state_nxt_s     = ST_DIG0;
                blank_cnt_nxt_s = {BW{1'b0}};
            end
        endcase
    end

    // Blank-slot dwell counter
    always_ff @(posedge i_clk) begin
        if (i_rst) blank_cnt_r <= {BW{1'b0}};
        else       blank_cnt_r <= blank_cnt_nxt_s;
    end
`else
    logic unused_blank_s;

    assign clr_s          = 1'b0;
    assign unused_blank_s = (BLANK_CYC > 0);

    // Plain two-slot scan; the frame boundary is DIG1 -> DIG0
    always_comb begin
        state_nxt_s = state_r;
        frame_s     = 1'b0;
        case (state_r)
            ST_DIG0: begin
                if (tick_s) state_nxt_s = ST_DIG1;
                else        state_nxt_s = ST_DIG0;
            end
            ST_DIG1: begin
                if (tick_s) begin
                    state_nxt_s = ST_DIG0;
                    frame_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_DIG1;
                end
            end
            default: state_nxt_s = ST_DIG0;
        endcase
    end
`endif

    // Output decode from the next state so registered outputs line up with the state
    always_comb begin
        dig_en_nxt_s = DIG_EN_OFF;
        s_nxt_s      = s_r;
        case (state_nxt_s)
            ST_DIG0: begin
                dig_en_nxt_s = DIG_EN_0;
                s_nxt_s      = 1'b0;
            end
            ST_DIG1: begin
                dig_en_nxt_s = DIG_EN_1;
                s_nxt_s      = 1'b1;
            end
            default: begin
                dig_en_nxt_s = DIG_EN_OFF;
                s_nxt_s      = s_r;
            end
        endcase
    end

    assign accept_s = i_valid & ready_r;
    assign commit_s = frame_s & pending_r;

    // State and scan outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_DIG0;
            s_r      <= 1'b0;
            dig_en_r <= DIG_EN_0;
            frame_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            s_r      <= s_nxt_s;
            dig_en_r <= dig_en_nxt_s;
            frame_r  <= frame_s;
        end
    end

    // Handshake and commit; ready is low exactly while a pair is pending, so both never coincide
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w0_r        <= 4'h0;
            w1_r        <= 4'h0;
            pend_data_r <= 8'h00;
            pending_r   <= 1'b0;
            ready_r     <= 1'b1;
        end else if (commit_s) begin
            w0_r      <= pend_data_r[3:0];
            w1_r      <= pend_data_r[7:4];
            pending_r <= 1'b0;
            ready_r   <= 1'b1;
        end else if (accept_s) begin
            pend_data_r <= i_data;
            pending_r   <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            pending_r <= pending_r;
            ready_r   <= ready_r;
        end
    end

    assign o_ready  = ready_r;
    assign o_s      = s_r;
    assign o_w0     = w0_r;
    assign o_w1     = w1_r;
    assign o_dig_en = dig_en_r;
    assign o_frame  = frame_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with PRESCALE=4, BLANK_CYC=2.
// Blank-slot scenario runs when MUX_SCAN_BLANK_EN is defined.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_valid;
    logic [7:0] i_data;
    logic       o_ready, o_s, o_frame;
    logic [3:0] o_w0, o_w1;
    logic [1:0] o_dig_en;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.PRESCALE(4), .BLANK_CYC(2)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_ready  (o_ready),
        .o_s      (o_s),
        .o_w0     (o_w0),
        .o_w1     (o_w1),
        .o_dig_en (o_dig_en),
        .o_frame  (o_frame)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b1; i_data = 8'hFF;
        step(2);
        chk("rst_s", {7'd0, o_s}, 8'h0);
        chk("rst_w0", {4'd0, o_w0}, 8'h0);
        chk("rst_w1", {4'd0, o_w1}, 8'h0);
        chk("rst_dig_en", {6'd0, o_dig_en}, 8'h1);
        chk("rst_ready", {7'd0, o_ready}, 8'h1);
        chk("rst_frame", {7'd0, o_frame}, 8'h0);
        i_rst = 1'b0; i_valid = 1'b0;

`ifdef MUX_SCAN_BLANK_EN
        begin
            logic [1:0] exp_en [13];
            logic       exp_s  [13];
            exp_en = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
            exp_s  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int k = 0; k < 13; k++) begin
                if (k > 0) step(1);
                chk("blank_seq_en", {6'd0, o_dig_en}, {6'd0, exp_en[k]});
                chk("blank_seq_s", {7'd0, o_s}, {7'd0, exp_s[k]});
            end
            chk("blank_frame", {7'd0, o_frame}, 8'h1);
            i_valid = 1'b1; i_data = 8'h5A;
            step(1);
            chk("blank_load_ready", {7'd0, o_ready}, 8'h0);
            i_valid = 1'b0;
            step(3);
            chk("blank0_reached", {6'd0, o_dig_en}, 8'h0);
            i_rst = 1'b1;
            step(1);
            chk("blank_rst_en", {6'd0, o_dig_en}, 8'h1);
            chk("blank_rst_ready", {7'd0, o_ready}, 8'h1);
            chk("blank_rst_s", {7'd0, o_s}, 8'h0);
            i_rst = 1'b0;
            step(4);
            chk("blank_rst_seq", {6'd0, o_dig_en}, 8'h0);
            step(8);
            chk("blank_rst_frame", {7'd0, o_frame}, 8'h1);
            chk("blank_rst_w0", {4'd0, o_w0}, 8'h0);
            chk("blank_rst_w1", {4'd0, o_w1}, 8'h0);
        end
`else
        // Free-running scan after reset release
        step(3);
        chk("dig0_hold", {7'd0, o_s}, 8'h0);
        step(1);
        chk("dig1_s", {7'd0, o_s}, 8'h1);
        chk("dig1_en", {6'd0, o_dig_en}, 8'h2);
        step(3);
        chk("pre_frame", {7'd0, o_frame}, 8'h0);
        step(1);
        chk("frame_s", {7'd0, o_s}, 8'h0);
        chk("frame_pulse", {7'd0, o_frame}, 8'h1);
        chk("frame_en", {6'd0, o_dig_en}, 8'h1);
        step(1);
        chk("frame_one_cycle", {7'd0, o_frame}, 8'h0);

        // Load A5 during DIG0
        i_valid = 1'b1; i_data = 8'hA5;
        step(1);
        chk("load_ready_low", {7'd0, o_ready}, 8'h0);
        i_valid = 1'b0;
        step(5);
        chk("load_w0_wait", {4'd0, o_w0}, 8'h0);
        chk("load_ready_wait", {7'd0, o_ready}, 8'h0);
        step(1);
        chk("load_w0", {4'd0, o_w0}, 8'h5);
        chk("load_w1", {4'd0, o_w1}, 8'hA);
        chk("load_frame", {7'd0, o_frame}, 8'h1);
        chk("load_ready_back", {7'd0, o_ready}, 8'h1);

        // Back-pressure: 3C then 7E with valid held
        i_valid = 1'b1; i_data = 8'h3C;
        step(1);
        chk("bp_ready_low", {7'd0, o_ready}, 8'h0);
        i_data = 8'h7E;
        step(6);
        chk("bp_w0_old", {4'd0, o_w0}, 8'h5);
        chk("bp_ready_held", {7'd0, o_ready}, 8'h0);
        step(1);
        chk("bp_w0_3c", {4'd0, o_w0}, 8'hC);
        chk("bp_w1_3c", {4'd0, o_w1}, 8'h3);
        chk("bp_ready_commit", {7'd0, o_ready}, 8'h1);
        step(1);
        chk("bp_7e_accepted", {7'd0, o_ready}, 8'h0);
        i_valid = 1'b0;
        step(7);
        chk("bp_w0_7e", {4'd0, o_w0}, 8'hE);
        chk("bp_w1_7e", {4'd0, o_w1}, 8'h7);
        chk("bp_frame", {7'd0, o_frame}, 8'h1);

        // Transfer on the exact boundary edge
        step(7);
        i_valid = 1'b1; i_data = 8'h12;
        step(1);
        chk("sim_frame", {7'd0, o_frame}, 8'h1);
        chk("sim_ready", {7'd0, o_ready}, 8'h0);
        chk("sim_w0_kept", {4'd0, o_w0}, 8'hE);
        chk("sim_w1_kept", {4'd0, o_w1}, 8'h7);
        i_valid = 1'b0;
        step(8);
        chk("sim_w0_next", {4'd0, o_w0}, 8'h2);
        chk("sim_w1_next", {4'd0, o_w1}, 8'h1);
        chk("sim_ready_back", {7'd0, o_ready}, 8'h1);

        // Freeze mid-DIG1 while a transfer is taken
        step(5);
        i_en = 1'b0; i_valid = 1'b1; i_data = 8'h9B;
        step(1);
        chk("frz_ready", {7'd0, o_ready}, 8'h0);
        chk("frz_s", {7'd0, o_s}, 8'h1);
        i_valid = 1'b0;
        step(9);
        chk("frz_s_end", {7'd0, o_s}, 8'h1);
        chk("frz_en_end", {6'd0, o_dig_en}, 8'h2);
        chk("frz_frame", {7'd0, o_frame}, 8'h0);
        chk("frz_w0", {4'd0, o_w0}, 8'h2);
        i_en = 1'b1;
        step(2);
        chk("resume_s", {7'd0, o_s}, 8'h1);
        chk("resume_w0_wait", {4'd0, o_w0}, 8'h2);
        step(1);
        chk("resume_s_dig0", {7'd0, o_s}, 8'h0);
        chk("resume_frame", {7'd0, o_frame}, 8'h1);
        chk("resume_w0", {4'd0, o_w0}, 8'hB);
        chk("resume_w1", {4'd0, o_w1}, 8'h9);
        chk("resume_ready", {7'd0, o_ready}, 8'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
